// File: rtl/fsel_pkg.sv
// Shared encodings for the FunSel register sequencer:
// register function selects, command opcodes and FSM states.
package fsel_pkg;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_DEC  = 3'b100;
    localparam logic [2:0] OP_UP   = 3'b101;
    localparam logic [2:0] OP_DOWN = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fsel_reg_sequencer.sv
// Expands clear/load/inc/dec/count-to commands into FunSel register
// strobes, reads the register back for count-to and reports wrap.
module fsel_reg_sequencer
    import fsel_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_cnt,
    input  logic [N-1:0]  reg_q,
    output logic [1:0]    fun_sel,
    output logic          reg_en,
    output logic [N-1:0]  reg_data,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result,
    output logic          wrap,
    output logic          err
);

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [N-1:0]  data_q;
    logic [N-1:0]  res_q;
    logic [CW-1:0] cnt_q;
    logic          wrap_q;

    logic          accept;
    logic          cnt_in;
    logic          cnt_op;
    logic          cnt_up;
    logic [CW-1:0] cnt_init;
    logic [N-1:0]  nxt_q;
    logic [1:0]    op_fs;

    assign accept = (state_q == S_IDLE) && cmd_valid;
    assign cnt_in = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
    assign cnt_op = (op_q == OP_UP) || (op_q == OP_DOWN);
    assign cnt_up = (op_q == OP_UP);
    assign nxt_q  = cnt_up ? reg_q + N'(1) : reg_q - N'(1);

    always_comb begin
        cnt_init = '0;
        unique case (cmd_op)
            OP_CLR, OP_LOAD: cnt_init = CW'(1);
            OP_INC, OP_DEC:  cnt_init = cmd_cnt;
            default:         cnt_init = '0;
        endcase
    end

    always_comb begin
        op_fs = FS_CLR;
        unique case (op_q)
            OP_LOAD:        op_fs = FS_LOAD;
            OP_INC, OP_UP:  op_fs = FS_INC;
            OP_DEC, OP_DOWN: op_fs = FS_DEC;
            default:        op_fs = FS_CLR;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        reg_en   = 1'b0;
        fun_sel  = FS_CLR;
        reg_data = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cnt_in)
                        state_d = (reg_q != cmd_data) ? S_EXEC : S_DONE;
                    else
                        state_d = (cnt_init != '0) ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (cnt_op) begin
                    if (reg_q == data_q) begin
                        state_d = S_DONE;
                    end else begin
                        reg_en  = 1'b1;
                        fun_sel = op_fs;
                        // Leave on the step that lands on target: k steps, k+1 cycles
                        if (nxt_q == data_q)
                            state_d = S_DONE;
                    end
                end else begin
                    reg_en   = 1'b1;
                    fun_sel  = op_fs;
                    reg_data = (op_q == OP_LOAD) ? data_q : '0;
                    if (cnt_q == CW'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                cnt_q  <= cnt_init;
                wrap_q <= 1'b0;
            end else begin
                if (state_q == S_EXEC && cnt_q != '0)
                    cnt_q <= cnt_q - CW'(1);
                if (reg_en && fun_sel == FS_INC && reg_q == '1)
                    wrap_q <= 1'b1;
                if (reg_en && fun_sel == FS_DEC && reg_q == '0)
                    wrap_q <= 1'b1;
            end
            if (state_q == S_DONE)
                res_q <= reg_q;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = done ? reg_q : res_q;
    assign wrap      = done & wrap_q;
    assign err       = done & (op_q == OP_ILL);

endmodule

// File: tb/tb_fsel_reg_sequencer.sv
// Bench for fsel_reg_sequencer driving a FunSel register model,
// checked against per-command arithmetic expectations.
module tb_fsel_reg_sequencer;
    import fsel_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic [3:0] rq = 4'h0;
    logic [1:0] fun_sel;
    logic       reg_en;
    logic [3:0] reg_data;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       wrap;
    logic       err;

    int n_pass = 0;
    int n_tot  = 0;

    fsel_reg_sequencer #(.N(4), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .reg_q     (rq),
        .fun_sel   (fun_sel),
        .reg_en    (reg_en),
        .reg_data  (reg_data),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    // FunSel register: no reset of its own, it survives sequencer reset
    always @(posedge clk) begin
        if (reg_en) begin
            case (fun_sel)
                FS_CLR:  rq <= 4'h0;
                FS_LOAD: rq <= reg_data;
                FS_DEC:  rq <= rq - 4'h1;
                default: rq <= rq + 4'h1;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected outcome of one command from the register's start value
    task automatic model(input logic [2:0] op, input logic [3:0] d,
                         input logic [3:0] c, input logic [3:0] r,
                         output int k, output logic [3:0] v,
                         output bit w, output bit e,
                         output logic [1:0] fs, output logic [3:0] rd);
        int ri, di, ci;
        ri = int'(r);
        di = int'(d);
        ci = int'(c);
        k = 0; v = r; w = 0; e = 0; fs = FS_CLR; rd = 4'h0;
        case (op)
            OP_CLR: begin k = 1; v = 4'h0; end
            OP_LOAD: begin k = 1; v = d; fs = FS_LOAD; rd = d; end
            OP_INC: begin
                k = ci; v = 4'((ri + ci) % 16); w = (ri + ci) > 15; fs = FS_INC;
            end
            OP_DEC: begin
                k = ci; v = 4'((ri - ci + 16) % 16); w = ci > ri; fs = FS_DEC;
            end
            OP_UP: begin
                k = (di - ri + 16) % 16; v = d; w = di < ri; fs = FS_INC;
            end
            OP_DOWN: begin
                k = (ri - di + 16) % 16; v = d; w = di > ri; fs = FS_DEC;
            end
            OP_ILL: e = 1;
            default: ;
        endcase
    endtask

    // Called on a negedge in IDLE; returns on the negedge after DONE
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] d,
                           input logic [3:0] c, input bit hold);
        int k, n, en_cnt;
        logic [3:0] v, rd;
        logic [1:0] fs;
        bit w, e, got;
        model(op, d, c, rq, k, v, w, e, fs, rd);
        check("ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = c;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            cmd_op   = OP_ILL;
            cmd_data = 4'($urandom);
            cmd_cnt  = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        n = 1; en_cnt = 0; got = 0;
        while (n <= 40 && !got) begin
            if (done) begin
                got = 1;
            end else begin
                if (reg_en) begin
                    en_cnt++;
                    check("fun_sel", 32'(fun_sel), 32'(fs));
                    check("reg_data", 32'(reg_data), 32'(rd));
                end
                @(negedge clk);
                n++;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(k + 1));
        check("steps", 32'(en_cnt), 32'(k));
        check("result", 32'(result), 32'(v));
        check("wrap", 32'(wrap), 32'(w));
        check("err", 32'(err), 32'(e));
        check("ready_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_post", 32'(cmd_ready), 32'd1);
        check("result_hold", 32'(result), 32'(v));
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = 4'h0;
        cmd_cnt   = 4'h0;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'(reg_en), 32'd0);
        check("rst_fs", 32'(fun_sel), 32'd0);
        check("rst_rd", 32'(reg_data), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(OP_LOAD, 4'h6, 4'h0, 0);
        run_cmd(OP_LOAD, 4'hE, 4'h0, 0);
        run_cmd(OP_INC, 4'h0, 4'h3, 0);
        run_cmd(OP_LOAD, 4'h5, 4'h0, 0);
        run_cmd(OP_DOWN, 4'h2, 4'h0, 0);
        run_cmd(OP_DOWN, 4'h2, 4'h0, 0);
        run_cmd(OP_INC, 4'h0, 4'h0, 0);
        run_cmd(OP_ILL, 4'h3, 4'h5, 0);
        run_cmd(OP_UP, 4'h1, 4'h0, 0);

        run_cmd(OP_CLR, 4'h0, 4'h0, 0);
        cmd_valid = 1'b1;
        cmd_op    = OP_INC;
        cmd_cnt   = 4'hA;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        check("abort_reg_pre", 32'(rq), 32'h4);
        rst_n = 1'b0;
        #1;
        check("abort_en", 32'(reg_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_reg", 32'(rq), 32'h4);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_reg_post", 32'(rq), 32'h4);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);

        run_cmd(OP_CLR, 4'h0, 4'h0, 1);
        run_cmd(OP_LOAD, 4'h9, 4'h0, 0);
        check("b2b_final", 32'(result), 32'h9);

        for (int i = 0; i < 25; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 4'($urandom),
                    4'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fsel_reg_sequencer.md
# fsel_reg_sequencer

Command-driven controller for the team's FunSel register (N-bit register with 2-bit function select and enable). It accepts one command at a time over a valid/ready handshake and expands it into a cycle-by-cycle sequence of `fun_sel`/`reg_en`/`reg_data` strobes. Supported commands are clear, load, N-step increment or decrement, and count-to-target. It reads the register output back to terminate count-to operations, reports wrap-around, and returns the final value with a one-cycle `done` pulse.

## Interface
- `N`, 4, data width; must match the controlled register.
- `CW`, 4, width of the step-count field.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  equals (state == IDLE); this includes the reset period.
- `cmd_op`  in  3  opcode (see Operation).
- `cmd_data`  in  N  load value or count target.
- `cmd_cnt`  in  CW  step count for INC/DEC.
- `reg_q`  in  N  current register output.
- `fun_sel`  out  2  register function: 00 clear, 01 load, 10 decrement, 11 increment.
- `reg_en`  out  1  register enable.
- `reg_data`  out  N  register data input.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  N  final register value.
- `wrap`  out  1  wrap-around occurred during the command.
- `err`  out  1  illegal opcode; valid with `done`.

## Operation
- Opcodes:
  - 000 NOP
  - 001 CLEAR
  - 010 LOAD `cmd_data`
  - 011 INC ×`cmd_cnt`
  - 100 DEC ×`cmd_cnt`
  - 101 COUNT_UP_TO `cmd_data`
  - 110 COUNT_DOWN_TO `cmd_data`
  - 111 illegal
- Accept: when `cmd_valid && cmd_ready` at a rising edge, latch op, data, and cnt. The step counter is loaded with 1 for CLEAR/LOAD, `cmd_cnt` for INC/DEC, and 0 for NOP/illegal.
- States: IDLE, EXEC, DONE.
  - IDLE → EXEC on accept with a nonzero step count, or for COUNT_*_TO with `reg_q` != target as sampled at the accept edge.
  - Otherwise IDLE → DONE.
- EXEC, fixed-count ops:
  - Drive `reg_en`=1 with the op's `fun_sel`; `reg_data` = latched data for LOAD, otherwise 0.
  - Decrement the counter every cycle; on the edge where the counter goes 1→0, EXEC → DONE.
- EXEC, COUNT_*_TO:
  - If `reg_q` == target: `reg_en`=0 and EXEC → DONE.
  - Otherwise step the register (11 or 10).
  - Termination is guaranteed within 2^N − 1 steps because the register wraps modulo 2^N.
- Wrap detection:
  - Set an internal sticky flag on any increment step with `reg_q` = all-ones, or any decrement step with `reg_q` = 0.
  - Clear the flag on accept.
- DONE:
  - `done`=1 and `result` = `reg_q`, combinational pass-through; the register has already updated.
  - `wrap` = sticky flag; `err` = (op == 111).
  - On the DONE → IDLE edge, capture `reg_q` into the result hold register. `result` shows that held value in IDLE and EXEC.
- Outside EXEC: `reg_en`=0, `fun_sel`=00, `reg_data`=0.
- This block never resets the register itself.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - State IDLE; `cmd_ready`=1; `busy`=0; `done`=0; `reg_en`=0.
  - `fun_sel`=00, `reg_data`=0, `result`=0, `wrap`=0, `err`=0.
  - Step counter and wrap flag are cleared.
- Reset mid-EXEC aborts immediately. The register keeps the steps already taken; no `done` is produced.
- Latency, accept edge to `done` cycle:
  - k register steps: k+1 cycles (k EXEC cycles, then DONE).
  - Zero-step command: 1 cycle.
- Throughput: `cmd_ready` is low from the accept edge until the DONE → IDLE edge. Back-to-back accepts are therefore at least 2 cycles apart.
- All outputs are decoded from registered state and counter, plus `reg_q` for COUNT_*_TO and `result`. No input-to-output path exists from `cmd_*`.
- `cmd_*` inputs are ignored outside IDLE.

## Structure
- Shared package `fsel_pkg`:
  - FunSel encodings (`FS_CLR`, `FS_LOAD`, `FS_DEC`, `FS_INC`).
  - Opcode constants.
  - State encoding typedef.
- Single module. The step counter and wrap flag are kept inline, with no sub-module.
- The bench instantiates this block with the FunSel register, `N`=4, wiring `reg_q` to the register output.

## Test plan
- Reset, then LOAD 0x6:
  - Next cycle: `reg_en`=1, `fun_sel`=01, `reg_data`=6.
  - Following cycle: `done`=1, `result`=6, `wrap`=0; `cmd_ready` returns the cycle after.
- Register at 0xE, INC cnt=3:
  - 3 cycles of `fun_sel`=11.
  - DONE: `result`=0x1, `wrap`=1.
- Register at 0x5, COUNT_DOWN_TO 0x2: 3 decrement cycles, `result`=0x2, `wrap`=0. Repeat with the register already at 0x2: no `reg_en`, `done` 1 cycle after accept.
- INC cnt=0: `done` 1 cycle after accept, no `reg_en`. Opcode 111: same timing, plus `err`=1.
- INC cnt=10 from 0x0, `rst_n` low after 4 steps:
  - Same instant: `reg_en`=0, `busy`=0, `cmd_ready`=1.
  - Register holds 0x4; no `done`.
- `cmd_valid` held high across CLEAR then LOAD 0x9: second accept on the edge after the first DONE, final `result`=0x9.
